// File: rtl/ssd_pkg.sv
// ssd_pkg
//   Shared constants for the seven-segment capture path.
//   - SEG_0..SEG_F : active-low segment patterns, bit6=g .. bit0=a
//   - SEG_BLANK    : all segments off
//   - SEG_TABLE    : patterns indexed by the nibble they represent
//   - state_t      : capture FSM encoding
package ssd_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } state_t;

endpackage

// File: rtl/ssd_seg_decode.sv
// ssd_seg_decode
//   Combinational inverse of the hex seven-segment encoder.
//   i_seg      : active-low segment pattern (bit6=g .. bit0=a)
//   o_nibble   : decoded hex value, 0 for blank or unknown patterns
//   o_is_blank : pattern is all segments off
//   o_is_err   : pattern is neither a hex digit nor blank
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_is_blank,
  output logic       o_is_err
);

  logic [15:0] w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_hit
      assign w_hit[gi] = (i_seg == SEG_TABLE[gi]);
    end
  endgenerate

  // Table entries are unique, so at most one hit bit is set.
  always_comb begin
    o_nibble = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (w_hit[k]) o_nibble = 4'(k);
    end
  end

  assign o_is_blank = (i_seg == SEG_BLANK);
  assign o_is_err   = ~o_is_blank & ~(|w_hit);

endmodule

// File: rtl/ssd_scan_capture.sv
// ssd_scan_capture
//   Samples the multiplexed anode/segment lines of a scanned display and
//   rebuilds the displayed NUM_DIGITS-digit hex value once every digit has
//   been captured at least once.
//   clk, reset   : clock, synchronous active-high reset
//   an_in        : active-low anode lines, bit i selects digit i
//   seg_in       : active-low segments, bit6=g .. bit0=a
//   value        : last complete frame, digit i in value[4i+3:4i]
//   blank_mask   : bit i set if digit i was blank in the last frame
//   frame_valid  : one-cycle pulse when value/blank_mask update
//   code_err     : one-cycle pulse after capturing an unknown pattern
module ssd_scan_capture
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    frame_valid,
  output logic                    code_err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  // The count lags the input by one edge, so the edge that completes
  // STABLE_CYCLES identical samples sees a count of STABLE_CYCLES-2.
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);

  logic [NUM_DIGITS-1:0]   r_an_q;
  logic [6:0]              r_seg_q;
  logic [CNT_W-1:0]        r_cnt;
  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_capture;
  logic                    w_changed;
  logic                    w_an_ok;
  logic                    w_frame_done;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [3:0]              r_shadow_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   r_shadow_blank;
  logic [4*NUM_DIGITS-1:0] w_shadow_flat;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic                    r_frame_valid;
  logic                    r_code_err;
  logic [3:0]              w_dec_nib;
  logic                    w_dec_blank;
  logic                    w_dec_err;

  ssd_seg_decode u_decode (
    .i_seg      (seg_in),
    .o_nibble   (w_dec_nib),
    .o_is_blank (w_dec_blank),
    .o_is_err   (w_dec_err)
  );

  assign w_changed    = ({an_in, seg_in} != {r_an_q, r_seg_q});
  assign w_an_ok      = ($countones(~an_in) == 1);
  assign w_frame_done = &r_seen;

  // Input history and stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_q  <= '0;
      r_seg_q <= '0;
      r_cnt   <= '0;
    end else begin
      r_an_q  <= an_in;
      r_seg_q <= seg_in;
      if (w_changed)             r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_an_ok) w_state_next = SETTLE;
      end
      SETTLE: begin
        if (!w_an_ok) begin
          w_state_next = IDLE;
        end else if (!w_changed && (r_cnt >= CNT_CAP)) begin
          w_capture    = 1'b1;
          w_state_next = CAPTURED;
        end
      end
      CAPTURED: begin
        if (!w_an_ok)       w_state_next = IDLE;
        else if (w_changed) w_state_next = SETTLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shadow slots: a capture writes the slot selected by the low anode bit.
  // Coverage clears on frame completion before a same-edge capture sets it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seen         <= '0;
      r_shadow_blank <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) r_shadow_nib[k] <= 4'd0;
    end else begin
      r_seen <= (w_frame_done ? '0 : r_seen) | (w_capture ? ~an_in : '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (w_capture && !an_in[k]) begin
          r_shadow_nib[k]   <= w_dec_nib;
          r_shadow_blank[k] <= w_dec_blank;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pack
      assign w_shadow_flat[4*gi +: 4] = r_shadow_nib[gi];
    end
  endgenerate

  // Output registers: value/blank_mask copy the shadow (pre-capture contents)
  // atomically on the completing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value       <= '0;
      r_blank       <= '0;
      r_frame_valid <= 1'b0;
      r_code_err    <= 1'b0;
    end else begin
      r_frame_valid <= w_frame_done;
      r_code_err    <= w_capture & w_dec_err;
      if (w_frame_done) begin
        r_value <= w_shadow_flat;
        r_blank <= r_shadow_blank;
      end
    end
  end

  assign value       = r_value;
  assign blank_mask  = r_blank;
  assign frame_valid = r_frame_valid;
  assign code_err    = r_code_err;

endmodule

// File: tb/tb_ssd_scan_capture.sv
module tb_ssd_scan_capture;

  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        frame_valid;
  logic        code_err;

  always #5 clk = ~clk;

  ssd_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .value       (value),
    .blank_mask  (blank_mask),
    .frame_valid (frame_valid),
    .code_err    (code_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] hex_pat [16];
  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] BAD = 7'b1010101;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         len;
  } run_t;
  run_t runs[$];

  typedef struct {
    logic [6:0]  s3, s2, s1, s0;
    logic [15:0] val;
    logic [3:0]  bl;
    int          errs;
  } vec_t;
  vec_t vecs[7];

  // Reference state: what has been captured so far and what is on the outputs.
  logic [3:0]  m_nib [4];
  logic [3:0]  m_bl_sh;
  logic [3:0]  m_seen;
  logic [15:0] m_out_val;
  logic [3:0]  m_out_bl;

  // Observations from the most recent play().
  int          obs_frames;
  int          obs_errs;
  int          obs_fv_edge;
  logic [15:0] obs_val;
  logic [3:0]  obs_bl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_decode(input logic [6:0] s, output logic [3:0] nib,
                                       output logic blank, output logic err);
    nib   = 4'd0;
    blank = (s == BLK);
    err   = !blank;
    for (int k = 0; k < 16; k++) begin
      if (hex_pat[k] == s) begin
        nib = 4'(k);
        err = 1'b0;
      end
    end
  endfunction

  function automatic bit one_digit(input logic [3:0] an);
    return ($countones(~an) == 1);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) m_nib[k] = 4'd0;
    m_bl_sh   = 4'd0;
    m_seen    = 4'd0;
    m_out_val = 16'd0;
    m_out_bl  = 4'd0;
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      an_in  = 4'($urandom);
      seg_in = 7'($urandom);
      @(posedge clk); #1;
    end
    if (chk) begin
      check("reset value", value, 16'd0);
      check("reset blank_mask", blank_mask, 4'd0);
      check("reset frame_valid", frame_valid, 1'b0);
      check("reset code_err", code_err, 1'b0);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic add_run(input logic [3:0] an, input logic [6:0] seg, input int len);
    run_t r;
    r.an = an; r.seg = seg; r.len = len;
    runs.push_back(r);
  endtask

  task automatic add_scan(input logic [6:0] s3, input logic [6:0] s2,
                          input logic [6:0] s1, input logic [6:0] s0, input int len);
    add_run(4'b0111, s3, len);
    add_run(4'b1011, s2, len);
    add_run(4'b1101, s1, len);
    add_run(4'b1110, s0, len);
  endtask

  // Plays the queued runs followed by a short idle gap. Expectations come from
  // run-level rules: a single-digit run lasting at least SC cycles captures on
  // its SC-th cycle; a frame is published one cycle after all digits are seen.
  task automatic play();
    run_t        m[$];
    int          total;
    int          e;
    bit          cap[];
    logic [6:0]  cap_seg[];
    logic [3:0]  cap_an[];
    bit          exp_fv[];
    bit          exp_err[];
    logic [15:0] exp_val[];
    logic [3:0]  exp_bl[];
    logic [3:0]  nib;
    logic        bl;
    logic        er;
    int          slot;

    add_run(4'b1111, BLK, 2);
    foreach (runs[i]) begin
      if (m.size() > 0 && m[m.size()-1].an == runs[i].an && m[m.size()-1].seg == runs[i].seg)
        m[m.size()-1].len += runs[i].len;
      else
        m.push_back(runs[i]);
    end
    runs.delete();

    total = 0;
    foreach (m[i]) total += m[i].len;
    cap = new[total]; cap_seg = new[total]; cap_an = new[total];
    exp_fv = new[total]; exp_err = new[total]; exp_val = new[total]; exp_bl = new[total];

    e = 0;
    foreach (m[i]) begin
      if (one_digit(m[i].an) && m[i].len >= SC) begin
        cap[e + SC - 1]     = 1'b1;
        cap_seg[e + SC - 1] = m[i].seg;
        cap_an[e + SC - 1]  = m[i].an;
      end
      e += m[i].len;
    end

    for (int t = 0; t < total; t++) begin
      exp_fv[t]  = 1'b0;
      exp_err[t] = 1'b0;
      exp_val[t] = 16'd0;
      exp_bl[t]  = 4'd0;
      if (m_seen == 4'hF) begin
        exp_fv[t]  = 1'b1;
        exp_val[t] = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        exp_bl[t]  = m_bl_sh;
        m_seen     = 4'd0;
      end
      if (cap[t]) begin
        model_decode(cap_seg[t], nib, bl, er);
        slot = 0;
        for (int k = 0; k < 4; k++) if (!cap_an[t][k]) slot = k;
        m_nib[slot]   = nib;
        m_bl_sh[slot] = bl;
        m_seen[slot]  = 1'b1;
        exp_err[t]    = er;
      end
    end

    obs_frames = 0; obs_errs = 0; obs_fv_edge = -1; obs_val = 16'd0; obs_bl = 4'd0;
    e = 0;
    foreach (m[i]) begin
      for (int c = 0; c < m[i].len; c++) begin
        an_in  = m[i].an;
        seg_in = m[i].seg;
        @(posedge clk); #1;
        if (exp_fv[e]) begin
          m_out_val = exp_val[e];
          m_out_bl  = exp_bl[e];
        end
        check("frame_valid", frame_valid, exp_fv[e]);
        check("code_err", code_err, exp_err[e]);
        check("value", value, m_out_val);
        check("blank_mask", blank_mask, m_out_bl);
        if (frame_valid) begin
          obs_frames++;
          obs_fv_edge = e;
          obs_val     = value;
          obs_bl      = blank_mask;
        end
        if (code_err) obs_errs++;
        e++;
      end
    end
  endtask

  initial begin
    hex_pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    vecs[0] = '{hex_pat[1], hex_pat[2], hex_pat[3], hex_pat[4], 16'h1234, 4'b0000, 0};
    vecs[1] = '{BLK, hex_pat[2], hex_pat[3], hex_pat[4], 16'h0234, 4'b1000, 0};
    vecs[2] = '{hex_pat[1], hex_pat[2], hex_pat[3], BAD, 16'h1230, 4'b0000, 1};
    vecs[3] = '{hex_pat[8], hex_pat[0], hex_pat[15], hex_pat[12], 16'h80FC, 4'b0000, 0};
    vecs[4] = '{hex_pat[13], hex_pat[14], hex_pat[11], hex_pat[9], 16'hDEB9, 4'b0000, 0};
    vecs[5] = '{BLK, BLK, hex_pat[7], BAD, 16'h0070, 4'b1100, 1};
    vecs[6] = '{hex_pat[5], hex_pat[6], hex_pat[10], BLK, 16'h56A0, 4'b0001, 0};

    an_in = 4'hF; seg_in = BLK; reset = 1'b1;
    model_clear();

    // Reset state with arbitrary inputs.
    do_reset(1'b1);

    // Table-driven frames: each digit held exactly SC cycles, order 3,2,1,0.
    for (int i = 0; i < 7; i++) begin
      add_scan(vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0, 4);
      play();
      check($sformatf("vec%0d frames", i), obs_frames, 1);
      check($sformatf("vec%0d value", i), obs_val, vecs[i].val);
      check($sformatf("vec%0d blank", i), obs_bl, vecs[i].bl);
      check($sformatf("vec%0d code_err pulses", i), obs_errs, vecs[i].errs);
      check($sformatf("vec%0d latency", i), obs_fv_edge, 16);
    end

    // Reset mid-frame discards digits 0,1; digits 2,3 alone never complete.
    do_reset(1'b0);
    add_run(4'b1110, hex_pat[4], 4);
    add_run(4'b1101, hex_pat[3], 4);
    play();
    do_reset(1'b1);
    add_run(4'b1011, hex_pat[2], 4);
    add_run(4'b0111, hex_pat[1], 4);
    play();
    check("mid-frame reset frames", obs_frames, 0);

    // Three-cycle holds never capture.
    do_reset(1'b0);
    add_scan(hex_pat[1], hex_pat[2], hex_pat[3], hex_pat[4], 3);
    play();
    check("short hold frames", obs_frames, 0);

    // Segment glitch on digit 0 restarts its stability count.
    do_reset(1'b0);
    add_run(4'b0111, hex_pat[1], 4);
    add_run(4'b1011, hex_pat[2], 4);
    add_run(4'b1101, hex_pat[3], 4);
    add_run(4'b1110, hex_pat[4], 1);
    add_run(4'b1110, hex_pat[1], 1);
    add_run(4'b1110, hex_pat[4], 3);
    play();
    check("glitch frames", obs_frames, 0);
    add_run(4'b1110, hex_pat[4], 4);
    play();
    check("after glitch frames", obs_frames, 1);
    check("after glitch value", obs_val, 16'h1234);

    // Ghost anode states, then a normal scan.
    do_reset(1'b0);
    add_run(4'b1100, hex_pat[1], 10);
    add_run(4'b1111, hex_pat[2], 10);
    play();
    check("ghost frames", obs_frames, 0);
    add_scan(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 4);
    play();
    check("post-ghost frames", obs_frames, 1);
    check("post-ghost value", obs_val, 16'h1234);

    // Same anode, changing segments: slot is overwritten.
    add_run(4'b1110, 7'b0011001, 4);
    add_run(4'b1110, 7'b0001000, 4);
    add_run(4'b1101, hex_pat[3], 4);
    add_run(4'b1011, hex_pat[2], 4);
    add_run(4'b0111, hex_pat[1], 4);
    play();
    check("overwrite frames", obs_frames, 1);
    check("overwrite value", obs_val, 16'h123A);

    // Back-to-back scans.
    add_scan(hex_pat[1], hex_pat[2], hex_pat[3], hex_pat[4], 4);
    add_scan(hex_pat[5], hex_pat[6], hex_pat[7], hex_pat[8], 4);
    play();
    check("back-to-back frames", obs_frames, 2);
    check("back-to-back value", obs_val, 16'h5678);

    // Randomized run sequences against the run-level reference.
    for (int it = 0; it < 60; it++) begin
      int         nr;
      logic [3:0] an;
      logic [6:0] sg;
      if ($urandom_range(0, 7) == 0) do_reset(1'b0);
      nr = $urandom_range(3, 9);
      for (int r = 0; r < nr; r++) begin
        if ($urandom_range(0, 3) != 0) begin
          an = 4'hF;
          an[$urandom_range(0, 3)] = 1'b0;
        end else begin
          case ($urandom_range(0, 4))
            0:       an = 4'b1111;
            1:       an = 4'b1100;
            2:       an = 4'b0000;
            3:       an = 4'b1010;
            default: an = 4'b0110;
          endcase
        end
        case ($urandom_range(0, 4))
          0:       sg = BLK;
          1:       sg = 7'($urandom);
          default: sg = hex_pat[$urandom_range(0, 15)];
        endcase
        add_run(an, sg, $urandom_range(1, 7));
      end
      play();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
